// File: rtl/router_output_arbiter.sv
// Output-channel arbiter: per-VC round-robin grant into single-entry VC buffers, polarity-gated drain to the link.
// Latency: grant -> VC buffer on 1 edge; buffer -> so on the next edge whose polarity matches the VC with ri high (min 2 cycles req->so).
// Backpressure: ri low holds the polarity VC buffer; a full buffer blocks new grants for its VC until it drains.
module router_output_arbiter #(
    parameter int PACKET_WIDTH = 64,
    parameter int NUM_REQ      = 5,
    parameter int VC_BIT       = 63
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            polarity,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]              gnt,
    input  logic                            ri,
    output logic                            so,
    output logic [PACKET_WIDTH-1:0]         so_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [PACKET_WIDTH-1:0] pkt_t;
    typedef logic [PTR_W-1:0]        ptr_t;

    localparam ptr_t LAST_IDX = ptr_t'(NUM_REQ - 1);

    // Per-source packets and their VC classification.
    pkt_t               pkt      [NUM_REQ];
    logic [NUM_REQ-1:0] vc_req   [2];

    // Per-VC state: single-entry buffer and round-robin pointer.
    logic [1:0]         buf_full;
    pkt_t               buf_data [2];
    ptr_t               rr_ptr   [2];

    // Per-VC arbitration result.
    logic [1:0]         win_vld;
    ptr_t               win_idx  [2];
    logic [1:0]         grant;

    // Drain of the VC selected by the current polarity.
    logic               drain;
    logic [1:0]         drain_vec;

    // Pointer advance past the winner, wrapping at the last source.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Slice the flattened request bus and split requests by the packet VC bit.
    always_comb begin
        vc_req[0] = '0;
        vc_req[1] = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pkt[i]       = req_data[i*PACKET_WIDTH +: PACKET_WIDTH];
            vc_req[0][i] = req[i] & ~pkt[i][VC_BIT];
            vc_req[1][i] = req[i] &  pkt[i][VC_BIT];
        end
    end

    // Round-robin search per VC: first requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        int idx;
        idx = 0;
        for (int v = 0; v < 2; v++) begin
            win_vld[v] = 1'b0;
            win_idx[v] = '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr[v]) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!win_vld[v] && vc_req[v][idx]) begin
                    win_vld[v] = 1'b1;
                    win_idx[v] = ptr_t'(idx);
                end
            end
        end
    end

    // A VC grants only into a buffer that is empty at the start of the cycle;
    // a buffer draining this cycle is not refilled until the next one.
    always_comb begin
        grant = win_vld & ~buf_full & {2{~reset}};
        gnt   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((grant[0] && (win_idx[0] == ptr_t'(i))) ||
                (grant[1] && (win_idx[1] == ptr_t'(i)))) begin
                gnt[i] = 1'b1;
            end
        end
    end

    // Only the VC matching the polarity may drain, and only with downstream ready.
    always_comb begin
        drain        = buf_full[polarity] & ri;
        drain_vec    = 2'b00;
        drain_vec[0] = drain & ~polarity;
        drain_vec[1] = drain &  polarity;
    end

    // VC buffers and pointers: capture winner on grant, free on drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full <= 2'b00;
            for (int v = 0; v < 2; v++) begin
                buf_data[v] <= '0;
                rr_ptr[v]   <= '0;
            end
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (grant[v]) begin
                    buf_data[v] <= pkt[win_idx[v]];
                    rr_ptr[v]   <= ptr_inc(win_idx[v]);
                end
            end
            buf_full <= (buf_full & ~drain_vec) | grant;
        end
    end

    // Link output register: one-cycle send strobe, data holds between sends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            so      <= 1'b0;
            so_data <= '0;
        end else begin
            so <= drain;
            if (drain) begin
                so_data <= buf_data[polarity];
            end
        end
    end

endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter: queue-driven sources, behavioural per-VC model, per-cycle compare.
// Inputs change 1 time unit after each rising edge; outputs are compared on the falling edge.
// Directed scenarios end with hand-computed literal expectations.
module tb_router_output_arbiter;

    localparam int PW = 64;
    localparam int N  = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            polarity;
    logic [N-1:0]    req;
    logic [N*PW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            ri;
    logic            so;
    logic [PW-1:0]   so_data;

    router_output_arbiter #(.PACKET_WIDTH(PW), .NUM_REQ(N), .VC_BIT(63)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .ri       (ri),
        .so       (so),
        .so_data  (so_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Source packet stores (one FIFO per source).
    logic [63:0] src_mem [N][16];
    int          src_head [N];
    int          src_tail [N];

    // Behavioural model state.
    bit          m_full [2];
    logic [63:0] m_data [2];
    int          m_ptr  [2];
    bit          m_so;
    logic [63:0] m_do;

    // Observation logs.
    bit          pol_auto;
    bit          edge_pol;
    logic [63:0] obs_data [64];
    bit          obs_pol  [64];
    int          obs_n = 0;
    int          vc0_log  [64];
    int          vc0_n  = 0;
    int          g2_cnt = 0;
    int          so_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_head[i] < src_tail[i]) begin
                req[i]              = 1'b1;
                req_data[i*PW +: PW] = src_mem[i][src_head[i]];
            end else begin
                req[i]              = 1'b0;
                req_data[i*PW +: PW] = '0;
            end
        end
    endtask

    task automatic push(input int s, input logic [63:0] p);
        src_mem[s][src_tail[s]] = p;
        src_tail[s]++;
        drive_inputs();
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        drive_inputs();
    endtask

    // Expected grant: per VC, with an empty buffer, the first requester for that VC
    // scanning (ptr + k) mod N for k = 0..N-1.
    function automatic logic [N-1:0] calc_arb(output bit v0, output bit v1,
                                              output int w0, output int w1);
        logic [N-1:0] g;
        bit           av [2];
        int           aw [2];
        int           i;
        g = '0;
        for (int v = 0; v < 2; v++) begin
            av[v] = 1'b0;
            aw[v] = 0;
            if (!reset && !m_full[v]) begin
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr[v] + k) % N;
                    if (!av[v] && req[i] && ((req_data[i*PW + 63] ? 1 : 0) == v)) begin
                        av[v] = 1'b1;
                        aw[v] = i;
                        g[i]  = 1'b1;
                    end
                end
            end
        end
        v0 = av[0]; v1 = av[1]; w0 = aw[0]; w1 = aw[1];
        return g;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_full[v] = 1'b0;
            m_data[v] = '0;
            m_ptr[v]  = 0;
        end
        m_so = 1'b0;
        m_do = '0;
    endtask

    // One clock edge of the model, using the pre-edge inputs and state.
    task automatic model_edge();
        logic [N-1:0] g;
        bit           av [2];
        int           aw [2];
        int           p;
        g = calc_arb(av[0], av[1], aw[0], aw[1]);
        p = edge_pol ? 1 : 0;
        if (m_full[p] && ri) begin
            m_so      = 1'b1;
            m_do      = m_data[p];
            m_full[p] = 1'b0;
        end else begin
            m_so = 1'b0;
        end
        for (int v = 0; v < 2; v++) begin
            if (av[v]) begin
                m_data[v] = req_data[aw[v]*PW +: PW];
                m_full[v] = 1'b1;
                m_ptr[v]  = (aw[v] + 1) % N;
                src_head[aw[v]]++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_pol = polarity;
        if (!reset) model_edge();
        #1;
        if (so && obs_n < 64) begin
            obs_data[obs_n] = so_data;
            obs_pol[obs_n]  = edge_pol;
            obs_n++;
        end
        if (pol_auto) polarity = ~polarity;
        drive_inputs();
    endtask

    // Per-cycle comparison against the model, plus grant/send logging.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        bit           d0, d1;
        int           e0, e1;
        eg = calc_arb(d0, d1, e0, e1);
        chk("gnt", 64'(gnt), 64'(eg));
        chk("so", 64'(so), 64'(m_so));
        chk("do", so_data, m_do);
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                if (!req_data[i*PW + 63] && vc0_n < 64) begin
                    vc0_log[vc0_n] = i;
                    vc0_n++;
                end
                if (i == 2) g2_cnt++;
            end
        end
        if (so) so_cnt++;
    end

    initial begin
        int nobs0;
        int vbase;
        int g2_base;
        int so_base;
        reset    = 1'b1;
        polarity = 1'b0;
        ri       = 1'b1;
        pol_auto = 1'b1;
        req      = '0;
        req_data = '0;
        model_reset();
        clear_srcs();

        // Reset with every source requesting.
        push(0, 64'h0000_0000_0000_0010);
        push(1, 64'h8000_0000_0000_0011);
        push(2, 64'h0000_0000_0000_0012);
        push(3, 64'h8000_0000_0000_0013);
        push(4, 64'h0000_0000_0000_0014);
        step();
        step();
        #5;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_so", 64'(so), 64'h0);
        chk("rst_do", so_data, 64'h0);
        step();
        reset = 1'b0;
        #5;
        chk("first_gnt", 64'(gnt), 64'h03);
        repeat (16) step();

        // Round-robin among sources 1, 2, 4 on VC0.
        vbase = vc0_n;
        nobs0 = obs_n;
        push(1, 64'h11); push(1, 64'h12);
        push(2, 64'h21); push(2, 64'h22);
        push(4, 64'h41); push(4, 64'h42);
        repeat (20) step();
        chk("rr_g0", 64'(vc0_log[vbase + 0]), 64'd1);
        chk("rr_g1", 64'(vc0_log[vbase + 1]), 64'd2);
        chk("rr_g2", 64'(vc0_log[vbase + 2]), 64'd4);
        chk("rr_g3", 64'(vc0_log[vbase + 3]), 64'd1);
        chk("rr_d0", obs_data[nobs0 + 0], 64'h11);
        chk("rr_d1", obs_data[nobs0 + 1], 64'h21);
        chk("rr_d2", obs_data[nobs0 + 2], 64'h41);
        chk("rr_d3", obs_data[nobs0 + 3], 64'h12);

        // Dual VC grant in one cycle.
        pol_auto = 1'b0;
        polarity = 1'b0;
        nobs0 = obs_n;
        push(0, 64'h0000_0000_0000_00A1);
        push(3, 64'h8000_0000_0000_00B3);
        #5;
        chk("dual_gnt", 64'(gnt), 64'h09);
        step();
        polarity = 1'b1;
        step();
        polarity = 1'b0;
        step();
        pol_auto = 1'b1;
        chk("dual_cnt", 64'(obs_n - nobs0), 64'd2);
        chk("dual_d0", obs_data[nobs0], 64'h8000_0000_0000_00B3);
        chk("dual_p0", 64'(obs_pol[nobs0]), 64'd1);
        chk("dual_d1", obs_data[nobs0 + 1], 64'h0000_0000_0000_00A1);
        chk("dual_p1", 64'(obs_pol[nobs0 + 1]), 64'd0);

        // Backpressure: ri low with VC0 full and source 2 waiting.
        ri = 1'b0;
        push(0, 64'hC0);
        step();
        push(2, 64'hC2);
        g2_base = g2_cnt;
        so_base = so_cnt;
        repeat (6) step();
        chk("bp_gnt2", 64'(g2_cnt - g2_base), 64'd0);
        chk("bp_so", 64'(so_cnt - so_base), 64'd0);
        ri = 1'b1;
        nobs0 = obs_n;
        repeat (8) step();
        chk("bp_d0", obs_data[nobs0], 64'hC0);
        chk("bp_p0", 64'(obs_pol[nobs0]), 64'd0);
        chk("bp_d1", obs_data[nobs0 + 1], 64'hC2);

        // Polarity gating: VC1 packet waits while polarity stays 0.
        pol_auto = 1'b0;
        polarity = 1'b0;
        push(4, 64'h8000_0000_0000_00D4);
        step();
        nobs0 = obs_n;
        repeat (4) step();
        chk("pg_hold", 64'(obs_n - nobs0), 64'd0);
        polarity = 1'b1;
        step();
        chk("pg_cnt", 64'(obs_n - nobs0), 64'd1);
        chk("pg_d", obs_data[nobs0], 64'h8000_0000_0000_00D4);
        pol_auto = 1'b1;

        // Asynchronous reset with both buffers loaded.
        ri = 1'b0;
        push(0, 64'hE0);
        push(1, 64'h8000_0000_0000_00E1);
        step();
        ri = 1'b1;
        step();
        chk("pre_rst_so", 64'(so), 64'h1);
        #2;
        reset = 1'b1;
        model_reset();
        clear_srcs();
        #1;
        chk("arst_so", 64'(so), 64'h0);
        chk("arst_do", so_data, 64'h0);
        step();
        step();
        reset = 1'b0;
        nobs0 = obs_n;
        repeat (10) step();
        chk("no_stale", 64'(obs_n - nobs0), 64'd0);
        push(3, 64'h77);
        repeat (6) step();
        chk("post_cnt", 64'(obs_n - nobs0), 64'd1);
        chk("post_d", obs_data[nobs0], 64'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
